divider_seq: RTL and testbench
==============================

DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 Parameter: W, default 4, operand width in bits (4 = full product width of the 2x2 multiplier).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  W  unsigned dividend; captured on the accepting edge.
REQ-006 divisor  input  W  unsigned divisor; captured on the accepting edge.
REQ-007 busy  output  1  high from the accepting edge until done deasserts.
REQ-008 done  output  1  one-cycle pulse; quotient and remainder are valid.
REQ-009 quotient  output  W  unsigned quotient; registered.
REQ-010 remainder  output  W  unsigned remainder; registered.
REQ-011 div_by_zero  output  1  high with done when the captured divisor is 0; held until next accept.

Function
REQ-012 Algorithm: restoring division, MSB first, one quotient bit per clock, with a W+1-bit partial remainder to avoid overflow.
REQ-013 States: IDLE, RUN, DONE; encoded as an enumerated type.
REQ-014 IDLE: start=1 -> latch operands, clear div_by_zero, busy=1; divisor!=0 -> RUN with iteration counter=W-1; divisor==0 -> DONE.
REQ-015 RUN: each cycle shift partial remainder left by one and bring in the next dividend bit; subtract divisor if result >= divisor and set quotient bit; counter==0 -> DONE, else decrement.
REQ-016 DONE: done=1 for exactly one cycle, then IDLE; busy falls with done.
REQ-017 Latency: non-zero divisor -> done high in the cycle after edge W+1 counted from the accepting edge (W=4: 5 clocks); zero divisor -> done in the cycle after the next edge (1 clock).
REQ-018 Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-019 Result identity for non-zero divisor: quotient*divisor + remainder == dividend, and remainder < divisor.
REQ-020 start while busy (RUN or DONE): ignored; in-flight operands are not disturbed.
REQ-021 Operand inputs may change freely after the accepting edge without effect.
REQ-022 quotient, remainder and div_by_zero hold their last values in IDLE until the next accepted start.
REQ-023 Back-to-back: start high in the IDLE cycle immediately after DONE is accepted normally.

Reset
REQ-024 rst=1 asynchronously forces IDLE; busy, done, div_by_zero = 0; quotient, remainder, counter and internal partial remainder = 0.
REQ-025 rst during RUN or DONE aborts the operation; no done pulse is produced for the aborted division.
REQ-026 First start after rst deasserts is accepted on the next rising edge.

Structure
REQ-027 Package divider_pkg holds the state enum type and the default width constant (4).
REQ-028 Single sub-module divider_step (combinational): one restoring iteration. Inputs: partial remainder, divisor, next dividend bit. Outputs: new partial remainder and quotient bit.
REQ-029 Top level holds the FSM, the counter and the registers only; no multiply or divide operators are used in synthesizable RTL.

Verification
REQ-030 W=4, 13/3 -> after 5 clocks done=1, quotient=4, remainder=1, div_by_zero=0; busy high for 5 cycles.
REQ-031 W=4, 7/0 -> after 1 clock done=1, quotient=15, remainder=7, div_by_zero=1.
REQ-032 W=4, 2/9 -> quotient=0, remainder=2; 15/1 -> quotient=15, remainder=0.
REQ-033 W=4, start 12/5, pulse start=1 with 1/1 during RUN -> only one done: quotient=2, remainder=2.
REQ-034 rst asserted in 3rd RUN cycle -> all outputs 0 immediately, no done pulse; then 9/2 -> quotient=4, remainder=1.
REQ-035 Exhaustive W=4 sweep of all 256 operand pairs -> REQ-019 holds for divisor!=0 (checked against the multiplier model), REQ-018 holds for divisor=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

    // Default operand width; 4 bits covers the full product of a 2x2 multiplier.
    localparam int DIVIDER_W_DEFAULT = 4;

    // Controller states: waiting for a request, iterating, presenting the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : divider_pkg

// File: rtl/divider_step.sv
// One restoring-division iteration: shift the partial remainder left, bring in
// the next dividend bit, and subtract the divisor when it fits.
module divider_step
    import divider_pkg::*;
#(
    parameter int W = DIVIDER_W_DEFAULT
) (
    input  logic [W:0]   prem_i,     // partial remainder before this step
    input  logic [W-1:0] divisor_i,  // captured divisor
    input  logic         bit_i,      // next dividend bit, MSB first
    output logic [W:0]   prem_o,     // partial remainder after this step
    output logic         qbit_o      // quotient bit produced by this step
);

    // One guard bit above the W+1-bit remainder keeps the shift lossless even
    // if the incoming remainder were ever at its maximum.
    logic [W+1:0] shifted;
    logic [W+1:0] divisor_ext;

    // Trial subtraction; restore (keep the shifted value) when the divisor does not fit.
    // NOTE: every output gets a value on every path so no latch is inferred.
    always_comb begin
        shifted     = {prem_i, bit_i};
        divisor_ext = {2'b00, divisor_i};
        qbit_o      = (shifted >= divisor_ext);
        if (qbit_o) begin
            prem_o = (W+1)'(shifted - divisor_ext);
        end else begin
            prem_o = (W+1)'(shifted);
        end
    end

endmodule : divider_step

// File: rtl/divider_seq.sv
// Sequential unsigned divider: one quotient bit per clock, MSB first, using
// restoring division. A zero divisor short-circuits straight to the result.
module divider_seq
    import divider_pkg::*;
#(
    parameter int W = DIVIDER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    // Iteration counter counts W-1 down to 0, so it only needs to hold W-1.
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    // Partial remainder, one bit wider than the operands.
    logic [W:0]       prem_q,  prem_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
    // after W steps this register holds the finished quotient.
    logic [W-1:0]     dvd_q,   dvd_d;
    logic [W-1:0]     dvs_q,   dvs_d;
    // Result registers: only written when a division completes, so they hold
    // their values through IDLE and the next operation's RUN phase.
    logic [W-1:0]     quot_q,  quot_d;
    logic [W-1:0]     rem_q,   rem_d;
    logic             dbz_q,   dbz_d;

    logic [W:0]       step_prem;
    logic             step_qbit;

    divider_step #(
        .W (W)
    ) u_step (
        .prem_i    (prem_q),
        .divisor_i (dvs_q),
        .bit_i     (dvd_q[W-1]),
        .prem_o    (step_prem),
        .qbit_o    (step_qbit)
    );

    // Next-state, datapath update and status outputs for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    prem_d = '0;
                    dbz_d  = 1'b0;
                    if (divisor == '0) begin
                        // Divide by zero: answer is known immediately.
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = CNT_W'(W - 1);
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                busy   = 1'b1;
                prem_d = step_prem;
                dvd_d  = {dvd_q[W-2:0], step_qbit};
                if (cnt_q == '0) begin
                    // Last iteration: publish the result as it is formed.
                    quot_d  = {dvd_q[W-2:0], step_qbit};
                    rem_d   = step_prem[W-1:0];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    // NOTE: the datapath registers are reset as well as the FSM because their
    // reset value of zero is visible on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule : divider_seq

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: table vectors, corner-case sequences
// and an exhaustive operand sweep, with results checked through a scoreboard.
module tb_divider_seq;
    import divider_pkg::*;

    localparam int W       = DIVIDER_W_DEFAULT;
    localparam int MAX_CYC = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    divider_seq #(
        .W (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    int n_vec    = 0;
    int n_miss   = 0;
    int done_cnt = 0;

    // Every done pulse is counted so extra or missing pulses can be detected.
    always @(posedge done) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent reference for the sweep and hand-written sequences.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Drive one accepted start; returns at the negedge just after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb_q.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Wait (bounded) for done, then pop and compare against the scoreboard.
    // Cycle 1 is the negedge right after the accepting edge.
    task automatic wait_done(input int exp_lat, input string tag);
        int   cyc;
        int   busy_cyc;
        exp_t e;
        cyc      = 1;
        busy_cyc = 0;
        forever begin
            if (busy) busy_cyc++;
            if (done || cyc >= MAX_CYC) break;
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            check({tag, " done timeout"}, 0, 1);
            if (sb_q.size() > 0) e = sb_q.pop_front();
            return;
        end
        if (sb_q.size() == 0) begin
            check({tag, " unexpected done"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, " quotient"},    32'(quotient),    32'(e.q));
        check({tag, " remainder"},   32'(remainder),   32'(e.r));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(e.z));
        if (exp_lat > 0) begin
            check({tag, " latency"},     32'(cyc),      32'(exp_lat));
            check({tag, " busy cycles"}, 32'(busy_cyc), 32'(exp_lat));
        end
    endtask

    initial begin
        int d0;
        exp_t e;

        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0, 5};
        vecs[1] = '{4'd7,  4'd0,  4'd15, 4'd7,  1'b1, 1};
        vecs[2] = '{4'd2,  4'd9,  4'd0,  4'd2,  1'b0, 5};
        vecs[3] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0, 5};
        vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0, 5};
        vecs[5] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0, 5};
        vecs[6] = '{4'd15, 4'd0,  4'd15, 4'd15, 1'b1, 1};
        vecs[7] = '{4'd8,  4'd3,  4'd2,  4'd2,  1'b0, 5};
        vecs[8] = '{4'd1,  4'd15, 4'd0,  4'd1,  1'b0, 5};
        vecs[9] = '{4'd14, 4'd4,  4'd3,  4'd2,  1'b0, 5};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset busy",        32'(busy),        0);
        check("reset done",        32'(done),        0);
        check("reset quotient",    32'(quotient),    0);
        check("reset remainder",   32'(remainder),   0);
        check("reset div_by_zero", 32'(div_by_zero), 0);
        rst = 1'b0;

        // Table vectors, issued back to back (start in the IDLE cycle after DONE).
        for (int i = 0; i < 10; i++) begin
            e.q = vecs[i].q;
            e.r = vecs[i].r;
            e.z = vecs[i].z;
            start_op(vecs[i].a, vecs[i].b, e);
            wait_done(vecs[i].lat, $sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b));
        end

        // Results hold in IDLE.
        repeat (3) @(negedge clk);
        check("idle hold quotient",  32'(quotient),  32'(vecs[9].q));
        check("idle hold remainder", 32'(remainder), 32'(vecs[9].r));
        check("idle busy",           32'(busy),      0);

        // start pulse during RUN is ignored; exactly one done for 12/5.
        d0 = done_cnt;
        start_op(4'd12, 4'd5, model(4'd12, 4'd5));
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(-1, "busy-start 12/5");
        repeat (8) @(negedge clk);
        check("busy-start done count", 32'(done_cnt - d0), 1);
        check("busy-start idle",       32'(busy),          0);

        // Reset in the third RUN cycle aborts without a done pulse.
        d0 = done_cnt;
        start_op(4'd11, 4'd3, model(4'd11, 4'd3));
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort busy",        32'(busy),        0);
        check("abort done",        32'(done),        0);
        check("abort quotient",    32'(quotient),    0);
        check("abort remainder",   32'(remainder),   0);
        check("abort div_by_zero", 32'(div_by_zero), 0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort no done", 32'(done_cnt - d0), 0);
        start_op(4'd9, 4'd2, '{4'd4, 4'd1, 1'b0});
        wait_done(5, "after-reset 9/2");

        // Exhaustive sweep with an arithmetic identity check.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(W'(a), W'(b), model(W'(a), W'(b)));
                wait_done((b == 0) ? 1 : 5, $sformatf("sweep %0d/%0d", a, b));
                if (b != 0) begin
                    check($sformatf("identity %0d/%0d", a, b),
                          32'(int'(quotient) * b + int'(remainder)), 32'(a));
                    check($sformatf("rem<div %0d/%0d", a, b),
                          32'(int'(remainder) < b), 1);
                end else begin
                    check($sformatf("dbz rem %0d", a), 32'(remainder), 32'(a));
                end
            end
        end

        check("scoreboard drained", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_divider_seq
